// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared definitions for the multi-cycle RV32I stage sequencer: state encoding,
// opcode constants and instruction field positions.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StHalt = 3'd5,
      StTrap = 3'd6
   } seq_state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpOp     = 7'b0110011;
   localparam logic [6:0] OpOpImm  = 7'b0010011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpSystem = 7'b1110011;

   localparam int unsigned OpcodeLsb = 0;
   localparam int unsigned OpcodeMsb = 6;
   localparam int unsigned RdLsb     = 7;
   localparam int unsigned RdMsb     = 11;

   // Opcodes the sequencer knows a stage path for; anything else traps in ID.
   function automatic logic is_legal_op(input logic [6:0] op);
      case (op)
         OpLoad, OpStore, OpOp, OpOpImm, OpLui, OpAuipc,
         OpJal, OpJalr, OpBranch, OpSystem: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_stage_sequencer_if.sv
// Control/handshake bundle between the stage sequencer (master) and the datapath (slave).
interface cpu_stage_sequencer_if;
   logic [31:0] w_ir;
   logic        w_imem_ready;
   logic        w_dmem_ready;
   logic        w_imem_req;
   logic        w_ir_we;
   logic        w_alu_go;
   logic        w_dmem_re;
   logic        w_dmem_we;
   logic        w_rf_we;
   logic        w_pc_we;
   logic [2:0]  w_state;
   logic        w_halted;
   logic        w_trap;
   logic [31:0] w_retired;

   modport master (
      input  w_ir, w_imem_ready, w_dmem_ready,
      output w_imem_req, w_ir_we, w_alu_go, w_dmem_re, w_dmem_we, w_rf_we, w_pc_we,
      output w_state, w_halted, w_trap, w_retired
   );

   modport slave (
      output w_ir, w_imem_ready, w_dmem_ready,
      input  w_imem_req, w_ir_we, w_alu_go, w_dmem_re, w_dmem_we, w_rf_we, w_pc_we,
      input  w_state, w_halted, w_trap, w_retired
   );
endinterface

// File: rtl/cpu_stage_sequencer_mem_wait_timer.sv
// Wait-state timer: counts stalled cycles and flags when MEM_TIMEOUT is reached.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired
);
   localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CntW-1:0] Limit = CntW'(MEM_TIMEOUT);

   logic [CntW-1:0] r_count;

   // Saturating stall counter, zeroed whenever the sequencer changes state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count_en && !o_expired) begin
         r_count <= r_count + CntW'(1);
      end
   end

   assign o_expired = (r_count == Limit);
endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the RV32I core.
// Optional retired-instruction counter enabled by CPU_SEQ_RETIRE_CNT_EN.
module cpu_stage_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned HALT_REG    = 30
) (
   input logic                    w_clk,
   input logic                    w_rst_n,
   cpu_stage_sequencer_if.master  io_bus
);
   seq_state_e r_state;
   seq_state_e w_next_state;

   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic       w_is_store;
   logic       w_expired;
   logic       w_count_en;
   logic       w_state_chg;
   logic       w_imem_req, w_ir_we, w_alu_go, w_dmem_re, w_dmem_we, w_rf_we, w_pc_we;
   logic       w_unused_ir;

   assign w_opcode    = io_bus.w_ir[OpcodeMsb:OpcodeLsb];
   assign w_rd        = io_bus.w_ir[RdMsb:RdLsb];
   assign w_is_store  = (w_opcode == OpStore);
   assign w_unused_ir = ^io_bus.w_ir[31:12];

   // State register; reset returns to IF immediately, aborting any instruction.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= StIf;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and strobe decode; strobes held low throughout reset.
   always_comb begin
      w_next_state = r_state;
      w_count_en   = 1'b0;
      w_imem_req   = 1'b0;
      w_ir_we      = 1'b0;
      w_alu_go     = 1'b0;
      w_dmem_re    = 1'b0;
      w_dmem_we    = 1'b0;
      w_rf_we      = 1'b0;
      w_pc_we      = 1'b0;
      if (w_rst_n) begin
         case (r_state)
            StIf: begin
               w_imem_req = 1'b1;
               w_count_en = !io_bus.w_imem_ready;
               if (io_bus.w_imem_ready) begin
                  w_ir_we      = 1'b1;
                  w_next_state = StId;
               end else if (w_expired) begin
                  w_next_state = StTrap;
               end
            end
            StId: w_next_state = is_legal_op(w_opcode) ? StEx : StTrap;
            StEx: begin
               w_alu_go = 1'b1;
               case (w_opcode)
                  OpLoad, OpStore: w_next_state = StMem;
                  OpBranch: begin
                     w_pc_we      = 1'b1;
                     w_next_state = StIf;
                  end
                  OpSystem: begin
                     w_pc_we      = 1'b1;
                     w_next_state = StHalt;
                  end
                  default: w_next_state = StWb;
               endcase
            end
            StMem: begin
               w_dmem_we  = w_is_store;
               w_dmem_re  = !w_is_store;
               w_count_en = !io_bus.w_dmem_ready;
               if (io_bus.w_dmem_ready) begin
                  // Stores retire here; loads still need the writeback cycle.
                  w_pc_we      = w_is_store;
                  w_next_state = w_is_store ? StIf : StWb;
               end else if (w_expired) begin
                  w_next_state = StTrap;
               end
            end
            StWb: begin
               w_rf_we      = (w_rd != 5'd0);
               w_pc_we      = 1'b1;
               w_next_state = (w_rd == 5'(HALT_REG)) ? StHalt : StIf;
            end
            StHalt, StTrap: w_next_state = r_state;
            default:        w_next_state = StTrap;
         endcase
      end
   end

   assign w_state_chg = (w_next_state != r_state);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .i_clk      (w_clk),
      .i_rst_n    (w_rst_n),
      .i_clear    (w_state_chg),
      .i_count_en (w_count_en),
      .o_expired  (w_expired)
   );

   assign io_bus.w_imem_req = w_imem_req;
   assign io_bus.w_ir_we    = w_ir_we;
   assign io_bus.w_alu_go   = w_alu_go;
   assign io_bus.w_dmem_re  = w_dmem_re;
   assign io_bus.w_dmem_we  = w_dmem_we;
   assign io_bus.w_rf_we    = w_rf_we;
   assign io_bus.w_pc_we    = w_pc_we;
   assign io_bus.w_state    = r_state;
   assign io_bus.w_halted   = (r_state == StHalt);
   assign io_bus.w_trap     = (r_state == StTrap);

`ifdef CPU_SEQ_RETIRE_CNT_EN
   logic [31:0] r_retired;

   // One count per PC update, i.e. per retired instruction; wraps naturally.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_retired <= '0;
      end else if (w_pc_we) begin
         r_retired <= r_retired + 32'd1;
      end
   end

   assign io_bus.w_retired = r_retired;
`else
   assign io_bus.w_retired = '0;
`endif
endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer: directed cases plus random programs.
module tb_cpu_stage_sequencer;
   localparam int MemTimeout = 15;
   localparam int HaltReg    = 30;
   localparam int KIf   = 0;
   localparam int KHalt = 1;
   localparam int KTrap = 2;

   typedef struct {
      int lat;
      int rf;
      int alu;
      int mem;
      int kind;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   mon_en = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   exp_retired = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   cpu_stage_sequencer_if bus_if ();

   cpu_stage_sequencer #(
      .MEM_TIMEOUT (MemTimeout),
      .HALT_REG    (HaltReg)
   ) dut (
      .w_clk   (clk),
      .w_rst_n (rst_n),
      .io_bus  (bus_if.master)
   );

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: cycle cost of each stage path from the opcode class and wait counts.
   function automatic exp_t model(input logic [31:0] ir, input int iw, input int dw);
      exp_t e;
      logic [6:0] op;
      logic [4:0] rd;
      bit legal, writes;
      op = ir[6:0];
      rd = ir[11:7];
      e = '{lat: 0, rf: 0, alu: 0, mem: 0, kind: KIf};
      if (iw > MemTimeout) begin
         e.lat = MemTimeout + 1;
         e.kind = KTrap;
         return e;
      end
      legal = op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h73};
      if (!legal) begin
         e.lat = iw + 2;
         e.kind = KTrap;
         return e;
      end
      e.alu = 1;
      e.lat = iw + 3;
      writes = 1'b0;
      if (op == 7'h63) begin
         e.kind = KIf;
      end else if (op == 7'h73) begin
         e.kind = KHalt;
      end else if (op == 7'h03 || op == 7'h23) begin
         if (dw > MemTimeout) begin
            e.lat += MemTimeout + 1;
            e.mem = MemTimeout + 1;
            e.kind = KTrap;
            return e;
         end
         e.lat += dw + 1;
         e.mem = dw + 1;
         if (op == 7'h03) begin
            e.lat += 1;
            writes = 1'b1;
         end
      end else begin
         e.lat += 1;
         writes = 1'b1;
      end
      if (writes) begin
         e.rf = (rd != 5'd0) ? 1 : 0;
         e.kind = (rd == 5'(HaltReg)) ? KHalt : KIf;
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      int sel;
      logic [4:0] rd;
      logic [31:0] hi;
      logic [6:0] op;
      sel = $urandom_range(0, 19);
      rd = 5'($urandom_range(0, 31));
      hi = $urandom;
      if (rd == 5'd30 && $urandom_range(0, 3) != 0) rd = 5'd1;
      case (sel)
         0, 1, 2:  op = 7'h13;
         3, 4:     op = 7'h33;
         5:        op = 7'h37;
         6:        op = 7'h17;
         7:        op = 7'h6f;
         8:        op = 7'h67;
         9, 10, 11: op = 7'h03;
         12, 13:   op = 7'h23;
         14, 15:   op = 7'h63;
         16:       op = 7'h73;
         17:       op = 7'h7f;
         default:  op = 7'h13;
      endcase
      return {hi[31:12], rd, op};
   endfunction

   function automatic int rand_wait();
      int r;
      r = $urandom_range(0, 24);
      if (r == 24) return $urandom_range(14, 17);
      if (r < 12) return 0;
      return r % 4;
   endfunction

   // Issue one instruction: push expectation, then answer the DUT's requests after the waits.
   task automatic run_instr(input logic [31:0] ir, input int iw, input int dw);
      exp_t e;
      int ic, dc;
      bit fin, retired;
      e = model(ir, iw, dw);
      q.push_back(e);
      if (e.kind != KTrap) exp_retired++;
      bus_if.w_ir = ir;
      ic = 0;
      dc = 0;
      fin = 1'b0;
      for (int c = 0; c < 200 && !fin; c++) begin
         bus_if.w_imem_ready = (ic == iw);
         bus_if.w_dmem_ready = (dc == dw);
         #1;
         if (bus_if.w_imem_req) ic++;
         if (bus_if.w_dmem_re || bus_if.w_dmem_we) dc++;
         retired = bus_if.w_pc_we;
         @(posedge clk);
         @(negedge clk);
         if (retired || bus_if.w_state == 3'd5 || bus_if.w_state == 3'd6) fin = 1'b1;
      end
      bus_if.w_imem_ready = 1'b0;
      bus_if.w_dmem_ready = 1'b0;
      if (!fin) begin
         total++;
         bad++;
         $display("FAIL instr_timeout: ir=%h never finished, state=%0d", ir, bus_if.w_state);
      end
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      mon_en = 1'b1;
      bus_if.w_ir = '0;
      bus_if.w_imem_ready = 1'b0;
      bus_if.w_dmem_ready = 1'b0;
      q.delete();
      exp_retired = 0;
      @(negedge clk);
      #1;
      chk("rst_state", int'(bus_if.w_state), 0);
      chk("rst_imem_req", int'(bus_if.w_imem_req), 0);
      chk("rst_flags", int'({bus_if.w_halted, bus_if.w_trap}), 0);
      chk("rst_retired", int'(bus_if.w_retired), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic chk_retired();
`ifdef CPU_SEQ_RETIRE_CNT_EN
      chk("retired", int'(bus_if.w_retired), exp_retired);
`else
      chk("retired", int'(bus_if.w_retired), 0);
`endif
   endtask

   // Monitor: tallies strobes per instruction and scores on retire (pc_we) or trap entry.
   initial begin : monitor
      exp_t e;
      int cnt, rf, alu, mem, pc, nxt;
      cnt = 0; rf = 0; alu = 0; mem = 0; pc = 0; nxt = -1;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n || !mon_en) begin
            cnt = 0; rf = 0; alu = 0; mem = 0; pc = 0; nxt = -1;
         end else begin
            if (nxt >= 0) begin
               chk("next_state", int'(bus_if.w_state), (nxt == KHalt) ? 5 : 0);
               if (nxt == KHalt) chk("halted_flag", int'(bus_if.w_halted), 1);
               nxt = -1;
            end
            if (bus_if.w_state == 3'd6) begin
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk("trap_expected", e.kind, KTrap);
                  chk("trap_lat", cnt, e.lat);
                  chk("trap_alu", alu, e.alu);
                  chk("trap_mem", mem, e.mem);
                  chk("trap_rf", rf, 0);
                  chk("trap_pc", pc, 0);
                  chk("trap_flag", int'(bus_if.w_trap), 1);
                  cnt = 0; rf = 0; alu = 0; mem = 0; pc = 0;
               end
            end else if (bus_if.w_state != 3'd5) begin
               cnt++;
               rf += int'(bus_if.w_rf_we);
               alu += int'(bus_if.w_alu_go);
               mem += int'(bus_if.w_dmem_re || bus_if.w_dmem_we);
               pc += int'(bus_if.w_pc_we);
               if (bus_if.w_pc_we) begin
                  if (q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL stray_pc_we: got pc_we=1 want no retire, state=%0d",
                              bus_if.w_state);
                  end else begin
                     e = q.pop_front();
                     chk("retire_expected", int'(e.kind != KTrap), 1);
                     chk("lat", cnt, e.lat);
                     chk("rf_we_count", rf, e.rf);
                     chk("alu_go_count", alu, e.alu);
                     chk("dmem_cycles", mem, e.mem);
                     nxt = e.kind;
                  end
                  cnt = 0; rf = 0; alu = 0; mem = 0; pc = 0;
               end
            end
         end
      end
   end

   initial begin : stim
      int seen;
      bit found;
      bus_if.w_ir = '0;
      bus_if.w_imem_ready = 1'b0;
      bus_if.w_dmem_ready = 1'b0;
      do_reset();
      // Directed: ADDI, LW with 3 wait states, BEQ, SW, then ADDI x30 halts.
      run_instr(32'h00100093, 0, 0);
      run_instr(32'h00002283, 0, 3);
      run_instr(32'h00000063, 0, 0);
      run_instr(32'h00502023, 0, 0);
      chk_retired();
      run_instr(32'h00100F13, 0, 0);
      #3;
      chk("halt_flag", int'(bus_if.w_halted), 1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         seen += int'(bus_if.w_imem_req);
      end
      chk("halt_no_fetch", seen, 0);
      @(negedge clk);
      // Fetch never answered, illegal opcode, and timeout boundaries.
      do_reset();
      run_instr(32'h00100093, 100, 0);
      do_reset();
      run_instr(32'h0000007F, 0, 0);
      do_reset();
      run_instr(32'h00100093, 15, 0);
      run_instr(32'h00002283, 0, 15);
      run_instr(32'h00502023, 0, 16);
      do_reset();
      repeat (10) run_instr(32'h00100093, 0, 0);
      chk_retired();
      // Reset asserted while a load waits in MEM.
      do_reset();
      mon_en = 1'b0;
      bus_if.w_ir = 32'h00002283;
      bus_if.w_imem_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         #1;
         if (bus_if.w_state == 3'd3) found = 1'b1;
      end
      chk("reached_mem", int'(found), 1);
      chk("mem_dmem_re", int'(bus_if.w_dmem_re), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", int'(bus_if.w_state), 0);
      chk("async_rst_strobes", int'({bus_if.w_dmem_re, bus_if.w_pc_we, bus_if.w_rf_we}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Random programs, each ending at a halt, a trap or the length cap.
      for (int p = 0; p < 12; p++) begin
         do_reset();
         for (int i = 0; i < 40; i++) begin
            run_instr(rand_instr(), rand_wait(), rand_wait());
            if (bus_if.w_state == 3'd5 || bus_if.w_state == 3'd6) break;
         end
         chk_retired();
         @(negedge clk);
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
